// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate extender: mode codes and skid-buffer occupancy states.
// The rotator is included only when IMM_EXT_ROTATE_EN is defined.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    MODE_ZEXT     = 2'b00,
    MODE_SEXT     = 2'b01,
    MODE_SEXT_SHL = 2'b10,
    MODE_ROT      = 2'b11
  } imm_mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } skid_state_e;

  // The ARM rotated-immediate field: imm8 in [7:0], rotate count in [11:8].
  localparam int ROT_FIELD_W = 12;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational extension datapath: zero/sign extend, sign extend and shift, and ARM rotate.
// The rotator is built only when IMM_EXT_ROTATE_EN is defined; otherwise mode 11 flags an error.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 24,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] res_imm,
  output logic             res_trunc,
  output logic             res_mode_err
);

  localparam int SW = OUT_W + SHIFT;

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;
  logic [SW-1:0]    shl_full;
  logic             shl_trunc;

  assign zext     = OUT_W'(imm);
  assign sext     = OUT_W'($signed(imm));
  assign shl_full = SW'($signed(imm)) << SHIFT;
  // The shifted value overflowed if any discarded bit differs from the kept sign bit.
  assign shl_trunc = shl_full[SW-1:OUT_W] != {SHIFT{shl_full[OUT_W-1]}};

`ifdef IMM_EXT_ROTATE_EN
  logic [ROT_FIELD_W-1:0] rot_field;
  logic [OUT_W-1:0]       rot_base;
  logic [31:0]            rot_amt;
  logic [OUT_W-1:0]       rot;

  assign rot_field = ROT_FIELD_W'(imm);
  assign rot_base  = OUT_W'(rot_field[7:0]);
  assign rot_amt   = (32'(rot_field[11:8]) << 1) % 32'(OUT_W);
  // A shift by the full width yields zero, so rot_amt == 0 needs no special case.
  assign rot       = (rot_base >> rot_amt) | (rot_base << (32'(OUT_W) - rot_amt));
`endif

  // NOTE: every output gets a default before the case, so no path can infer a latch.
  always_comb begin
    res_imm      = zext;
    res_trunc    = 1'b0;
    res_mode_err = 1'b0;
    unique case (imm_mode_e'(mode))
      MODE_ZEXT:     res_imm = zext;
      MODE_SEXT:     res_imm = sext;
      MODE_SEXT_SHL: begin
        res_imm   = shl_full[OUT_W-1:0];
        res_trunc = shl_trunc;
      end
      MODE_ROT: begin
`ifdef IMM_EXT_ROTATE_EN
        res_imm = rot;
`else
        res_imm      = zext;
        res_mode_err = 1'b1;
`endif
      end
      default: res_imm = zext;
    endcase
  end

endmodule

// File: rtl/imm_extend_unit.sv
// Pipelined immediate extender with a valid/ready handshake and a 2-entry skid buffer.
// Set IMM_EXT_ROTATE_EN to build the ARM rotated-immediate mode.
module imm_extend_unit
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 24,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic             out_trunc,
  output logic             out_mode_err
);

  typedef struct packed {
    logic [OUT_W-1:0] imm;
    logic             trunc;
    logic             mode_err;
  } imm_ext_res_t;

  imm_ext_res_t new_res;
  imm_ext_res_t main_q;
  imm_ext_res_t skid_q;
  skid_state_e  state_q;
  skid_state_e  state_d;
  logic         in_ready_q;
  logic         in_fire;
  logic         out_fire;
  logic         load_main;
  logic         load_skid;
  logic         drain_skid;

  imm_ext_core #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .SHIFT(SHIFT)
  ) u_core (
    .imm         (in_imm),
    .mode        (in_mode),
    .res_imm     (new_res.imm),
    .res_trunc   (new_res.trunc),
    .res_mode_err(new_res.mode_err)
  );

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = (state_q != ST_EMPTY) & out_ready;

  always_comb begin
    state_d    = state_q;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    drain_skid = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d   = ST_ONE;
          load_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_d    = ST_ONE;
          drain_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      // NOTE: both data registers are reset because out_imm must read zero after reset.
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
      if (load_main) begin
        main_q <= new_res;
      end else if (drain_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= new_res;
      end
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = (state_q != ST_EMPTY);
  assign out_imm      = main_q.imm;
  assign out_trunc    = main_q.trunc;
  assign out_mode_err = main_q.mode_err;

endmodule

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench for imm_extend_unit: directed corner cases plus randomized traffic
// scored against an arithmetic reference model; honours IMM_EXT_ROTATE_EN like the RTL.
module tb_imm_extend_unit;
  import imm_ext_pkg::*;

  localparam int IN_W  = 24;
  localparam int OUT_W = 32;
  localparam int SHIFT = 2;

  typedef struct packed {
    logic [31:0] imm;
    logic        trunc;
    logic        err;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm = '0;
  logic [1:0]       in_mode = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [OUT_W-1:0] out_imm;
  logic             out_trunc;
  logic             out_mode_err;

  logic        l_in_valid = 1'b0;
  logic        l_in_ready;
  logic [3:0]  l_in_imm = '0;
  logic [1:0]  l_in_mode = '0;
  logic        l_out_valid;
  logic        l_out_ready = 1'b1;
  logic [15:0] l_out_imm;
  logic        l_out_trunc;
  logic        l_out_mode_err;

  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic [31:0] w_in_imm = '0;
  logic [1:0]  w_in_mode = '0;
  logic        w_out_valid;
  logic        w_out_ready = 1'b1;
  logic [31:0] w_out_imm;
  logic        w_out_trunc;
  logic        w_out_mode_err;

  imm_extend_unit #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_trunc(out_trunc), .out_mode_err(out_mode_err)
  );

  imm_extend_unit #(.IN_W(4), .OUT_W(16), .SHIFT(2)) dut_legacy (
    .clk(clk), .reset(reset), .in_valid(l_in_valid), .in_ready(l_in_ready), .in_imm(l_in_imm),
    .in_mode(l_in_mode), .out_valid(l_out_valid), .out_ready(l_out_ready), .out_imm(l_out_imm),
    .out_trunc(l_out_trunc), .out_mode_err(l_out_mode_err)
  );

  imm_extend_unit #(.IN_W(32), .OUT_W(32), .SHIFT(2)) dut_wide (
    .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_imm(w_in_imm),
    .in_mode(w_in_mode), .out_valid(w_out_valid), .out_ready(w_out_ready), .out_imm(w_out_imm),
    .out_trunc(w_out_trunc), .out_mode_err(w_out_mode_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: treat the field as an integer, scale it, and test whether it still fits.
  function automatic res_t ref_model(input int in_w, input int out_w, input int sh,
                                     input longint unsigned imm, input logic [1:0] mode);
    res_t              r;
    longint            sv;
    longint            prod;
    longint unsigned   mask;
    longint unsigned   imm8;
    int                amt;
    mask = (64'd1 << out_w) - 64'd1;
    sv   = imm[in_w-1] ? longint'(imm) - (longint'(1) << in_w) : longint'(imm);
    r    = '0;
    case (mode)
      2'b00: r.imm = 32'(imm);
      2'b01: r.imm = 32'(longint'(sv) & longint'(mask));
      2'b10: begin
        prod    = sv * (longint'(1) << sh);
        r.imm   = 32'(prod & longint'(mask));
        r.trunc = (prod < -(longint'(1) << (out_w - 1))) || (prod >= (longint'(1) << (out_w - 1)));
      end
      default: begin
`ifdef IMM_EXT_ROTATE_EN
        imm8  = imm & 64'hFF;
        amt   = int'((2 * ((imm >> 8) & 64'hF)) % longint'(out_w));
        r.imm = 32'(((imm8 >> amt) | (imm8 << (out_w - amt))) & mask);
`else
        r.imm = 32'(imm);
        r.err = 1'b1;
`endif
      end
    endcase
    return r;
  endfunction

  // Scoreboard on the main instance: expected words queue up at input fire, pop at output fire.
  res_t exp_q[$];
  res_t mon_e;
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_word", 64'(out_valid), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_data", 64'({out_imm, out_trunc, out_mode_err}), 64'(mon_e));
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(ref_model(IN_W, OUT_W, SHIFT, 64'(in_imm), in_mode));
    end
  end

  task automatic send_main(input logic [IN_W-1:0] imm, input logic [1:0] mode,
                           input logic [OUT_W-1:0] exp_imm, input logic exp_trunc,
                           input logic exp_err, input string tag);
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_imm    = imm;
    in_mode   = mode;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_valid"}, 64'(out_valid), 64'(1));
    check({tag, "_imm"}, 64'(out_imm), 64'(exp_imm));
    check({tag, "_flags"}, 64'({out_trunc, out_mode_err}), 64'({exp_trunc, exp_err}));
  endtask

  task automatic send_legacy(input logic [3:0] imm, input logic [1:0] mode,
                             input logic [15:0] exp_imm, input string tag);
    @(posedge clk); #1;
    l_in_valid = 1'b1;
    l_in_imm   = imm;
    l_in_mode  = mode;
    @(posedge clk); #1;
    l_in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_valid"}, 64'(l_out_valid), 64'(1));
    check({tag, "_imm"}, 64'(l_out_imm), 64'(exp_imm));
  endtask

  task automatic send_wide(input logic [31:0] imm, input logic [1:0] mode,
                           input logic [31:0] exp_imm, input logic exp_trunc, input string tag);
    @(posedge clk); #1;
    w_in_valid = 1'b1;
    w_in_imm   = imm;
    w_in_mode  = mode;
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_valid"}, 64'(w_out_valid), 64'(1));
    check({tag, "_imm"}, 64'(w_out_imm), 64'(exp_imm));
    check({tag, "_trunc"}, 64'(w_out_trunc), 64'(exp_trunc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  logic [IN_W-1:0] a_imm, b_imm, c_imm;
  res_t            a_exp, b_exp, c_exp;
  logic            acc;
  int              drain_cycles;

  initial begin
    // Reset with a valid input presented: it must be discarded.
    reset    = 1'b1;
    in_valid = 1'b1;
    in_imm   = 24'h123456;
    in_mode  = MODE_SEXT;
    @(posedge clk); @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_imm", 64'(out_imm), 64'(0));
    check("rst_flags", 64'({out_trunc, out_mode_err}), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_legacy_valid", 64'(l_out_valid), 64'(0));

    // Predecessor parity and wide-field overflow.
    send_legacy(4'b0011, MODE_SEXT, 16'h0003, "legacy_sext_pos");
    send_legacy(4'b1110, MODE_SEXT, 16'hFFFE, "legacy_sext_neg");
    send_wide(32'h40000000, MODE_SEXT_SHL, 32'h00000000, 1'b1, "wide_shl_trunc");
    send_wide(32'h20000000, MODE_SEXT_SHL, 32'h80000000, 1'b1, "wide_shl_signflip");
    send_wide(32'hE0000000, MODE_SEXT_SHL, 32'h80000000, 1'b0, "wide_shl_fits");

    // Default-width modes.
    send_main(24'hFFFFFE, MODE_SEXT_SHL, 32'hFFFFFFF8, 1'b0, 1'b0, "shl_neg");
    send_main(24'h000001, MODE_SEXT_SHL, 32'h00000004, 1'b0, 1'b0, "shl_pos");
    send_main(24'h800001, MODE_ZEXT, 32'h00800001, 1'b0, 1'b0, "zext_msb");
    send_main(24'h800001, MODE_SEXT, 32'hFF800001, 1'b0, 1'b0, "sext_msb");
`ifdef IMM_EXT_ROTATE_EN
    send_main(24'h0004FF, MODE_ROT, 32'hFF000000, 1'b0, 1'b0, "rot_on");
    send_main(24'hABC4FF, MODE_ROT, 32'hFF000000, 1'b0, 1'b0, "rot_on_upper_ignored");
    send_main(24'h000081, MODE_ROT, 32'h00000081, 1'b0, 1'b0, "rot_on_zero_count");
`else
    send_main(24'h0004FF, MODE_ROT, 32'h000004FF, 1'b0, 1'b1, "rot_off");
    send_main(24'hABC4FF, MODE_ROT, 32'h00ABC4FF, 1'b0, 1'b1, "rot_off_upper");
`endif

    // Back-pressure: A and B accepted, C held until the consumer drains.
    a_imm = 24'h00000A; b_imm = 24'hF0000B; c_imm = 24'h00000C;
    a_exp = ref_model(IN_W, OUT_W, SHIFT, 64'(a_imm), MODE_SEXT);
    b_exp = ref_model(IN_W, OUT_W, SHIFT, 64'(b_imm), MODE_SEXT);
    c_exp = ref_model(IN_W, OUT_W, SHIFT, 64'(c_imm), MODE_SEXT);
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = MODE_SEXT;
    in_imm    = a_imm;
    @(posedge clk); #1;
    in_imm = b_imm;
    @(negedge clk);
    check("bp_a_out", 64'(out_imm), 64'(a_exp.imm));
    check("bp_ready_after_a", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_imm = c_imm;
    @(negedge clk);
    check("bp_ready_low_after_b", 64'(in_ready), 64'(0));
    check("bp_a_held", 64'(out_imm), 64'(a_exp.imm));
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_c_still_held", 64'(in_ready), 64'(0));
    check("bp_a_still_held", 64'(out_imm), 64'(a_exp.imm));
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_b_next", 64'(out_imm), 64'(b_exp.imm));
    check("bp_ready_back", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_c_next_valid", 64'(out_valid), 64'(1));
    check("bp_c_next", 64'(out_imm), 64'(c_exp.imm));
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_drained", 64'(out_valid), 64'(0));

    // Streaming: 8 back-to-back words, no bubble, in_ready never drops.
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_imm   = IN_W'($urandom);
      in_mode  = 2'($urandom);
      @(negedge clk);
      check("stream_in_ready", 64'(in_ready), 64'(1));
      if (i > 0) check("stream_out_valid", 64'(out_valid), 64'(1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_last_valid", 64'(out_valid), 64'(1));
    @(posedge clk); #1;
    @(negedge clk);
    check("stream_done", 64'(out_valid), 64'(0));

    // Reset while FULL, with a stalled input and a ready consumer during reset.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_imm    = 24'h111111;
    @(posedge clk); #1;
    in_imm = 24'h222222;
    @(posedge clk); #1;
    in_imm = 24'h333333;
    @(negedge clk);
    check("rstfull_pre_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    reset     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rstfull_out_valid", 64'(out_valid), 64'(0));
    check("rstfull_out_imm", 64'(out_imm), 64'(0));
    check("rstfull_in_ready", 64'(in_ready), 64'(1));
    send_main(24'h7FFFFF, MODE_SEXT_SHL, 32'h01FFFFFC, 1'b0, 1'b0, "rstfull_first_word");

    // Randomized traffic with random back-pressure, scored by the monitor.
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_imm   = IN_W'($urandom);
        in_mode  = 2'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk); #1;
    if (!acc) begin
      drain_cycles = 0;
      while (!acc && drain_cycles < 20) begin
        out_ready = 1'b1;
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk); #1;
        drain_cycles++;
      end
      check("rand_last_accepted", 64'(acc), 64'(1));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain_cycles = 0;
    while (exp_q.size() != 0 && drain_cycles < 20) begin
      @(posedge clk); #1;
      drain_cycles++;
    end
    @(negedge clk);
    check("drain_queue_empty", 64'(exp_q.size()), 64'(0));
    check("drain_out_valid", 64'(out_valid), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
